rx_mac_discard_stats: RTL and testbench
=======================================

Name: rx_mac_discard_stats

Overview:
- Statistics stage directly downstream of each RX MAC Lite's discard MVB output (one instance per ETH channel), clocked in the core clock domain.
- Counts frames seen and frames discarded per cycle across all regions into saturating counters.
- Exposes atomic snapshots of both counters over an MI slave, with software snapshot and clear commands.

Parameters:
- REGIONS, 4, MVB regions per word (equals RX MAC Lite region count).
- CNT_WIDTH, 48, counter width; 33..64.
- MI_DATA_WIDTH, 32, MI data width; fixed at 32.
- MI_ADDR_WIDTH, 32, MI address width; only ADDR[4:2] is decoded.

Ports:
- CLK  in  1  core clock.
- RESET  in  1  asynchronous, active-high reset.
- RX_MVB_DATA  in  REGIONS  per-region discard flag (1 = frame discarded).
- RX_MVB_VLD  in  REGIONS  per-region frame-valid flag.
- RX_MVB_SRC_RDY  in  1  word valid. There is no DST_RDY; the block always accepts.
- MI_DWR  in  32  write data.
- MI_ADDR  in  MI_ADDR_WIDTH  byte address.
- MI_BE  in  4  byte enables.
- MI_RD  in  1  read request.
- MI_WR  in  1  write request.
- MI_ARDY  out  1  address ready.
- MI_DRD  out  32  read data.
- MI_DRDY  out  1  read data valid.

Behaviour:
- Reset: asynchronous clear of all state. The counters, snapshots, SNAP_VLD, pipeline stage, MI_DRD and MI_DRDY all reset to 0.
- Stage 1 (registered):
  - inc_tot = popcount(VLD) and inc_dis = popcount(VLD and DATA), both taken only when SRC_RDY=1; otherwise both are 0.
  - A region with DATA=1 and VLD=0 is ignored.
- Stage 2: tot_cnt += inc_tot and dis_cnt += inc_dis.
  - Both are saturating: the result is clamped to 2^CNT_WIDTH-1 and never wraps.
  - Latency: a word accepted in cycle t is visible in the counters in cycle t+2.
- Register map (ADDR[4:2]):
  - 0 CTRL/STATUS.
    - Write bit0 = snapshot, bit1 = clear; the write acts only if BE[0]=1.
    - Read returns bit0 = SNAP_VLD; other bits read 0.
  - 1 TOT_LO: snap_tot[31:0].
  - 2 TOT_HI: snap_tot[CNT_WIDTH-1:32], zero-extended.
  - 3 DIS_LO: snap_dis[31:0].
  - 4 DIS_HI: snap_dis[CNT_WIDTH-1:32], zero-extended.
  - 5..7: read 0; writes ignored.
  - Snapshot registers are read-only; writes to indices 1..4 are ignored.
- Snapshot command in cycle t:
  - snap_tot/snap_dis <= counter values present in cycle t (before any stage-2 add in that cycle).
  - SNAP_VLD <= 1.
- Clear command in cycle t:
  - Counters <= 0 and the stage-2 increment of cycle t is dropped.
  - Stage 1 is not flushed, so words accepted in cycle t and later are counted.
  - Snapshots and SNAP_VLD are unchanged.
- Snapshot and clear in the same write: the snapshot captures the pre-clear value, then the counters are zeroed.
- MI handshake:
  - MI_ARDY = MI_RD or MI_WR, combinational; there are no wait states.
  - Read in cycle t: MI_DRD and MI_DRDY=1 in cycle t+1; MI_DRDY=0 otherwise.
  - MI_DRD is held at its last value when MI_DRDY=0.
  - RD and WR asserted together: the write is executed and the read also returns data. The read returns the pre-write register value.
- Reset mid-operation: in-flight stage-1 increments are lost, and a pending MI_DRDY is deasserted.

Test Plan:
- Reset, then SRC_RDY=1, VLD=1111, DATA=0101 for 10 cycles, then snapshot and read all registers -> TOT_LO=40, DIS_LO=20, both HI=0, STATUS=1.
- Word with SRC_RDY=0, VLD=1111, DATA=1111 -> no change: after a snapshot, TOT_LO=0 and DIS_LO=0.
- Word VLD=0010, DATA=1100 -> after a snapshot, TOT_LO=1 and DIS_LO=0 (discard flag without valid is ignored).
- Force tot_cnt to 2^48-2 (backdoor), then send a VLD=1111 word and snapshot -> TOT_HI=0x0000FFFF, TOT_LO=0xFFFFFFFF (saturated, no wrap).
- Count 7 frames, write CTRL=0x3 while words keep streaming, then snapshot again later:
  - the first snapshot reads 7;
  - the second snapshot excludes the 7 frames and the increment dropped in the clear cycle, but includes words accepted from the clear cycle on.
- Read ADDR=0x1C -> MI_DRD=0, MI_DRDY exactly one cycle after RD. Write with BE=0000 to CTRL -> no snapshot; STATUS unchanged.

Source files
------------

// File: rtl/rx_mac_discard_stats_if.sv
// Bundles the discard MVB input and the MI slave bus of rx_mac_discard_stats.
interface rx_mac_discard_stats_if #(
    parameter int REGIONS       = 4,
    parameter int MI_ADDR_WIDTH = 32
);
    logic [REGIONS-1:0]       mvb_data;
    logic [REGIONS-1:0]       mvb_vld;
    logic                     mvb_src_rdy;
    logic [31:0]              mi_dwr;
    logic [MI_ADDR_WIDTH-1:0] mi_addr;
    logic [3:0]               mi_be;
    logic                     mi_rd;
    logic                     mi_wr;
    logic                     mi_ardy;
    logic [31:0]              mi_drd;
    logic                     mi_drdy;

    modport master (
        output mvb_data, mvb_vld, mvb_src_rdy,
        output mi_dwr, mi_addr, mi_be, mi_rd, mi_wr,
        input  mi_ardy, mi_drd, mi_drdy
    );

    modport slave (
        input  mvb_data, mvb_vld, mvb_src_rdy,
        input  mi_dwr, mi_addr, mi_be, mi_rd, mi_wr,
        output mi_ardy, mi_drd, mi_drdy
    );
endinterface

// File: rtl/rx_mac_discard_stats.sv
// Per-channel RX discard statistics: saturating frame/discard counters behind
// an MI register window with atomic snapshot and clear commands.
module rx_mac_discard_stats #(
    parameter int REGIONS       = 4,
    parameter int CNT_WIDTH     = 48,
    parameter int MI_DATA_WIDTH = 32,
    parameter int MI_ADDR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    rx_mac_discard_stats_if.slave  bus
);
    localparam int IW = $clog2(REGIONS + 1);

    logic [IW-1:0]            pc_tot, pc_dis;
    logic [IW-1:0]            inc_tot, inc_dis;
    logic [CNT_WIDTH-1:0]     tot_cnt, dis_cnt;
    logic [CNT_WIDTH-1:0]     snap_tot, snap_dis;
    logic                     snap_vld;
    logic [63:0]              snap_tot_x, snap_dis_x;
    logic [2:0]               idx;
    logic                     wr_ctrl, do_snap, do_clr;
    logic [MI_DATA_WIDTH-1:0] rd_data;
    logic                     unused;

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [IW-1:0] b);
        logic [CNT_WIDTH:0] s;
        s = {1'b0, a} + (CNT_WIDTH+1)'(b);
        return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
    endfunction

    // A discard flag only counts when its region also carries a valid frame.
    always_comb begin
        pc_tot = '0;
        pc_dis = '0;
        for (int i = 0; i < REGIONS; i++) begin
            pc_tot = pc_tot + IW'(bus.mvb_vld[i]);
            pc_dis = pc_dis + IW'(bus.mvb_vld[i] & bus.mvb_data[i]);
        end
    end

    assign idx     = bus.mi_addr[4:2];
    assign wr_ctrl = bus.mi_wr && (idx == 3'd0) && bus.mi_be[0];
    assign do_snap = wr_ctrl && bus.mi_dwr[0];
    assign do_clr  = wr_ctrl && bus.mi_dwr[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inc_tot <= '0;
            inc_dis <= '0;
        end else begin
            inc_tot <= bus.mvb_src_rdy ? pc_tot : '0;
            inc_dis <= bus.mvb_src_rdy ? pc_dis : '0;
        end
    end

    // Clear wins over the pending stage-2 add; stage 1 keeps flowing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tot_cnt <= '0;
            dis_cnt <= '0;
        end else if (do_clr) begin
            tot_cnt <= '0;
            dis_cnt <= '0;
        end else begin
            tot_cnt <= sat_add(tot_cnt, inc_tot);
            dis_cnt <= sat_add(dis_cnt, inc_dis);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_tot <= '0;
            snap_dis <= '0;
            snap_vld <= 1'b0;
        end else if (do_snap) begin
            snap_tot <= tot_cnt;
            snap_dis <= dis_cnt;
            snap_vld <= 1'b1;
        end
    end

    assign snap_tot_x = 64'(snap_tot);
    assign snap_dis_x = 64'(snap_dis);

    always_comb begin
        rd_data = '0;
        case (idx)
            3'd0:    rd_data = MI_DATA_WIDTH'(snap_vld);
            3'd1:    rd_data = snap_tot_x[31:0];
            3'd2:    rd_data = snap_tot_x[63:32];
            3'd3:    rd_data = snap_dis_x[31:0];
            3'd4:    rd_data = snap_dis_x[63:32];
            default: rd_data = '0;
        endcase
    end

    assign bus.mi_ardy = bus.mi_rd | bus.mi_wr;

    // Read data is sampled before this cycle's write lands, so RD+WR returns the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.mi_drdy <= 1'b0;
            bus.mi_drd  <= '0;
        end else begin
            bus.mi_drdy <= bus.mi_rd;
            if (bus.mi_rd)
                bus.mi_drd <= rd_data;
        end
    end

    assign unused = ^{bus.mi_addr[MI_ADDR_WIDTH-1:5], bus.mi_addr[1:0],
                      bus.mi_dwr[31:2], bus.mi_be[3:1]};
endmodule

// File: tb/tb_rx_mac_discard_stats.sv
// Bench for rx_mac_discard_stats: directed test-plan steps plus a random phase,
// all checked against a history-sum model of the counters and snapshots.
module tb_rx_mac_discard_stats;
    localparam longint unsigned MAXV = 64'h0000_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rx_mac_discard_stats_if #(.REGIONS(4), .MI_ADDR_WIDTH(32)) ifc();

    rx_mac_discard_stats #(
        .REGIONS(4), .CNT_WIDTH(48), .MI_DATA_WIDTH(32), .MI_ADDR_WIDTH(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    int nvec = 0;
    int nerr = 0;

    // Model: per-cycle accepted counts; a counter equals the sum of words
    // accepted from the last clear cycle up to two cycles ago, clamped.
    int               cyc = 0;
    int               h_tot [0:4095];
    int               h_dis [0:4095];
    int               last_clr = 0;
    int               base_cyc = 0;
    longint unsigned  base_tot = 0;
    longint unsigned  m_snap_tot = 0;
    longint unsigned  m_snap_dis = 0;
    logic             m_vld = 1'b0;
    logic [31:0]      held_drd = '0;

    function automatic longint unsigned cnt_val(input int t, input bit dis);
        longint unsigned s;
        int st;
        s  = dis ? 64'd0 : base_tot;
        st = dis ? last_clr : ((base_cyc > last_clr) ? base_cyc : last_clr);
        for (int c = st; c <= t - 2; c++)
            s += longint'(dis ? h_dis[c] : h_tot[c]);
        if (s > MAXV) s = MAXV;
        return s;
    endfunction

    function automatic logic [31:0] reg_val(input logic [2:0] i);
        case (i)
            3'd0:    return {31'd0, m_vld};
            3'd1:    return m_snap_tot[31:0];
            3'd2:    return m_snap_tot[63:32];
            3'd3:    return m_snap_dis[31:0];
            3'd4:    return m_snap_dis[63:32];
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit sr, input logic [3:0] v, input logic [3:0] d,
                        input bit rd, input bit wr, input logic [2:0] i,
                        input logic [31:0] dw, input logic [3:0] be);
        logic [31:0] exp_rd;
        logic [31:0] a;
        exp_rd = reg_val(i);
        a = $urandom();
        a[4:2] = i;
        a[1:0] = 2'b00;
        ifc.mvb_src_rdy = sr;
        ifc.mvb_vld     = v;
        ifc.mvb_data    = d;
        ifc.mi_rd       = rd;
        ifc.mi_wr       = wr;
        ifc.mi_addr     = a;
        ifc.mi_dwr      = dw;
        ifc.mi_be       = be;
        h_tot[cyc] = sr ? $countones(v) : 0;
        h_dis[cyc] = sr ? $countones(v & d) : 0;
        if (wr && i == 3'd0 && be[0]) begin
            if (dw[0]) begin
                m_snap_tot = cnt_val(cyc, 1'b0);
                m_snap_dis = cnt_val(cyc, 1'b1);
                m_vld = 1'b1;
            end
            if (dw[1]) begin
                last_clr = cyc;
                base_tot = 0;
            end
        end
        #1;
        chk("ardy", ifc.mi_ardy, rd | wr);
        @(posedge clk);
        #1;
        cyc++;
        chk("drdy", ifc.mi_drdy, rd);
        if (rd) held_drd = exp_rd;
        chk(rd ? "drd" : "drd_hold", ifc.mi_drd, held_drd);
    endtask

    task automatic idle();
        step(0, 4'h0, 4'h0, 0, 0, 3'd0, 32'd0, 4'h0);
    endtask

    task automatic ctrl(input logic [31:0] dw);
        step(0, 4'h0, 4'h0, 0, 1, 3'd0, dw, 4'h1);
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] i, input logic [31:0] exp);
        step(0, 4'h0, 4'h0, 1, 0, i, 32'd0, 4'h0);
        chk(tag, ifc.mi_drd, exp);
    endtask

    initial begin
        ifc.mvb_src_rdy = 0; ifc.mvb_vld = '0; ifc.mvb_data = '0;
        ifc.mi_rd = 0; ifc.mi_wr = 0; ifc.mi_addr = '0; ifc.mi_dwr = '0; ifc.mi_be = '0;
        for (int c = 0; c < 4096; c++) begin h_tot[c] = 0; h_dis[c] = 0; end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_drdy", ifc.mi_drdy, 1'b0);
        chk("rst_drd", ifc.mi_drd, 32'd0);
        rst = 1'b0;

        // reset state of the register window
        rd_chk("rst_status", 3'd0, 32'd0);
        rd_chk("rst_tot_lo", 3'd1, 32'd0);
        rd_chk("rst_tot_hi", 3'd2, 32'd0);
        rd_chk("rst_dis_lo", 3'd3, 32'd0);
        rd_chk("rst_dis_hi", 3'd4, 32'd0);
        rd_chk("addr_1c", 3'd7, 32'd0);
        idle();

        // BE[0]=0 write to CTRL does nothing
        step(0, 4'h0, 4'h0, 0, 1, 3'd0, 32'h3, 4'he);
        rd_chk("be0_status", 3'd0, 32'd0);

        // RD+WR together: read returns the pre-write status
        step(0, 4'h0, 4'h0, 1, 1, 3'd0, 32'h1, 4'h1);
        chk("rdwr_pre", ifc.mi_drd, 32'd0);
        rd_chk("rdwr_post", 3'd0, 32'd1);

        // 10 words of VLD=1111 DATA=0101
        repeat (10) step(1, 4'hf, 4'h5, 0, 0, 3'd0, 32'd0, 4'h0);
        idle(); idle();
        ctrl(32'h1);
        rd_chk("t1_status", 3'd0, 32'd1);
        rd_chk("t1_tot_lo", 3'd1, 32'd40);
        rd_chk("t1_tot_hi", 3'd2, 32'd0);
        rd_chk("t1_dis_lo", 3'd3, 32'd20);
        rd_chk("t1_dis_hi", 3'd4, 32'd0);

        // SRC_RDY=0 word is not counted
        ctrl(32'h2); idle(); idle();
        step(0, 4'hf, 4'hf, 0, 0, 3'd0, 32'd0, 4'h0);
        idle(); idle();
        ctrl(32'h1);
        rd_chk("t2_tot_lo", 3'd1, 32'd0);
        rd_chk("t2_dis_lo", 3'd3, 32'd0);

        // discard flag without valid is ignored
        ctrl(32'h2);
        step(1, 4'h2, 4'hc, 0, 0, 3'd0, 32'd0, 4'h0);
        idle(); idle();
        ctrl(32'h1);
        rd_chk("t3_tot_lo", 3'd1, 32'd1);
        rd_chk("t3_dis_lo", 3'd3, 32'd0);

        // saturation from a backdoor preload
        ctrl(32'h2); idle(); idle();
        force dut.tot_cnt = 48'hFFFF_FFFF_FFFE;
        idle();
        release dut.tot_cnt;
        base_tot = 64'h0000_FFFF_FFFF_FFFE;
        base_cyc = cyc;
        step(1, 4'hf, 4'h0, 0, 0, 3'd0, 32'd0, 4'h0);
        idle(); idle();
        ctrl(32'h1);
        rd_chk("sat_hi", 3'd2, 32'h0000_FFFF);
        rd_chk("sat_lo", 3'd1, 32'hFFFF_FFFF);

        // snapshot+clear while streaming
        ctrl(32'h2); idle(); idle();
        step(1, 4'hf, 4'h0, 0, 0, 3'd0, 32'd0, 4'h0);
        step(1, 4'h7, 4'h0, 0, 0, 3'd0, 32'd0, 4'h0);
        idle(); idle();
        step(1, 4'hf, 4'h3, 0, 0, 3'd0, 32'd0, 4'h0);
        step(1, 4'hf, 4'h3, 0, 1, 3'd0, 32'h3, 4'h1);
        repeat (4) step(1, 4'hf, 4'h3, 0, 0, 3'd0, 32'd0, 4'h0);
        idle(); idle();
        rd_chk("t5_snap1_tot", 3'd1, 32'd7);
        rd_chk("t5_snap1_dis", 3'd3, 32'd0);
        ctrl(32'h1);
        rd_chk("t5_snap2_tot", 3'd1, 32'd20);
        rd_chk("t5_snap2_dis", 3'd3, 32'd10);

        // random traffic, random register accesses
        for (int n = 0; n < 400; n++) begin
            bit          sr, rd, wr;
            logic [2:0]  i;
            sr = ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 7) < 3);
            wr = ($urandom_range(0, 15) < 3);
            i  = 3'($urandom_range(0, 7));
            if (wr && $urandom_range(0, 1) == 1) i = 3'd0;
            step(sr, 4'($urandom()), 4'($urandom()), rd, wr, i, $urandom(), 4'($urandom()));
        end
        idle(); idle();
        ctrl(32'h1);
        for (int i = 0; i < 5; i++)
            step(0, 4'h0, 4'h0, 1, 0, 3'(i), 32'd0, 4'h0);

        // asynchronous reset with a read response pending
        step(1, 4'hf, 4'hf, 1, 0, 3'd1, 32'd0, 4'h0);
        ifc.mvb_src_rdy = 0; ifc.mvb_vld = '0; ifc.mvb_data = '0;
        ifc.mi_rd = 0; ifc.mi_wr = 0;
        #2 rst = 1'b1;
        #1;
        chk("arst_drdy", ifc.mi_drdy, 1'b0);
        chk("arst_drd", ifc.mi_drd, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        h_tot[cyc] = 0; h_dis[cyc] = 0;
        cyc++;
        last_clr = cyc; base_tot = 0;
        m_snap_tot = 0; m_snap_dis = 0; m_vld = 1'b0; held_drd = '0;
        idle(); idle();
        ctrl(32'h1);
        rd_chk("post_rst_tot", 3'd1, 32'd0);
        rd_chk("post_rst_dis", 3'd3, 32'd0);
        rd_chk("post_rst_status", 3'd0, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
